cyclic_15_7_serial_encoder: RTL
===============================

CYCLIC_15_7_SERIAL_ENCODER -- requirements
Module: cyclic_15_7_serial_encoder

Interface
REQ-001 Parameters: none; N=15, K=7 and g(x)=1+x^4+x^6+x^7+x^8 SHALL be fixed internal constants.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  high while message bits are presented; a message SHALL occupy 7 consecutive load-high cycles.
REQ-005 message_bit  input  1  serial message, highest degree first (m6..m0).
REQ-006 code_bit  output  1  registered serial codeword bit, transmission order c14..c0.
REQ-007 code_valid  output  1  high on every cycle code_bit carries a codeword bit.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 codeword_done  output  1  one-cycle pulse coincident with the last parity bit (c0) on code_bit.
REQ-010 codeword  output  [0:14]  last completed codeword in transmission order; codeword[0]=c14, codeword[14]=c0.

Function
REQ-011 The encoder SHALL produce the systematic codeword c(x) = x^8*m(x) + (x^8*m(x) mod g(x)), with c14..c8 = m6..m0 and c7..c0 = parity r7..r0.
REQ-012 States SHALL be IDLE, MSG and PARITY, with a 4-bit bit counter and an 8-bit LFSR r[7:0].
REQ-013 IDLE, load=1: sample message_bit, update LFSR, set code_bit=message_bit and code_valid=1, counter=1, go to MSG.
REQ-014 IDLE, load=0: hold; code_valid=0, code_bit=0.
REQ-015 LFSR message step: fb = message_bit ^ r7; r0'=fb, r1'=r0, r2'=r1, r3'=r2, r4'=r3^fb, r5'=r4, r6'=r5^fb, r7'=r6^fb.
REQ-016 MSG, load=1: same sample/LFSR/output action and counter increment; after the edge that captures m0 (counter reaches 7), go to PARITY.
REQ-017 MSG, load=0: abort; go to IDLE, clear LFSR and counter, code_valid=0; codeword and codeword_done SHALL be unaffected.
REQ-018 PARITY: each edge sets code_bit=r7, code_valid=1, shifts r left with 0 into r0, and increments the counter; load and message_bit SHALL be ignored.
REQ-019 The edge outputting c0 (8th parity edge) SHALL pulse codeword_done, load codeword with all 15 bits, clear the LFSR, and go to IDLE.
REQ-020 Latency: c14 SHALL appear on code_bit one cycle after the first load-high edge; 15 valid bits SHALL follow contiguously.
REQ-021 Back-to-back: load=1 on the first IDLE edge after codeword_done SHALL start a new codeword, keeping code_valid continuously high.
REQ-022 A message shorter than 7 load-high cycles SHALL never produce codeword_done.

Reset
REQ-023 reset=1 SHALL immediately force IDLE and clear the counter, LFSR, code_bit, code_valid, busy, codeword_done and codeword to 0.
REQ-024 reset asserted mid-MSG or mid-PARITY SHALL discard the partial codeword. The first load-high edge after release SHALL start a fresh codeword.

Verification
REQ-025 Message 0000001 -> code_bit stream 000000111010001, codeword_done on the 15th valid cycle, codeword=000000111010001.
REQ-026 Message 1000000 -> stream 100000011101000, codeword=100000011101000.
REQ-027 Message 1111111 -> parity 11111111, codeword=111111111111111.
REQ-028 Two messages back-to-back (0000001 then 1000000, load high 7 cycles, low 8, high 7) -> code_valid high for 30 consecutive cycles, two codeword_done pulses, codeword updated each time.
REQ-029 load dropped after 4 message bits -> busy falls next cycle, no codeword_done, codeword unchanged; the following full 0000001 gives REQ-025 values.
REQ-030 reset pulsed during PARITY -> all outputs 0 asynchronously; the next full message 1000000 gives REQ-026 values.

Source files
------------

// File: rtl/cyclic_15_7_serial_encoder.sv
// Serial systematic encoder for the (15,7) cyclic code with g(x)=1+x^4+x^6+x^7+x^8.
// Message bits stream through unchanged, then the 8 parity bits are shifted out of the division LFSR.
module cyclic_15_7_serial_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        message_bit,
  output logic        code_bit,
  output logic        code_valid,
  output logic        busy,
  output logic        codeword_done,
  output logic [0:14] codeword
);

  localparam int unsigned N     = 15;
  localparam int unsigned K     = 7;
  localparam int unsigned P     = N - K;
  localparam int unsigned CNT_W = 4;

  // Bit i holds the coefficient of x^i; the x^8 term is implicit in the shift.
  localparam logic [P:0] GEN_POLY = 9'b1_1101_0001;

  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MSG    = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P-1:0]     lfsr_q, lfsr_d;
  logic [N-2:0]     sent_q, sent_d;
  logic             code_bit_q, code_bit_d;
  logic             code_valid_q, code_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [0:N-1]     codeword_q, codeword_d;

  logic [P-1:0]     lfsr_msg_step;
  logic [P-1:0]     lfsr_par_step;
  logic             fb;

  // Division step: feedback taps follow the low coefficients of g(x).
  always_comb begin
    fb            = message_bit ^ lfsr_q[P-1];
    lfsr_msg_step = {lfsr_q[P-2:0], 1'b0} ^ (fb ? GEN_POLY[P-1:0] : '0);
    lfsr_par_step = {lfsr_q[P-2:0], 1'b0};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    sent_d       = sent_q;
    code_bit_d   = 1'b0;
    code_valid_d = 1'b0;
    done_d       = 1'b0;
    codeword_d   = codeword_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          lfsr_d       = lfsr_msg_step;
          code_bit_d   = message_bit;
          code_valid_d = 1'b1;
          sent_d       = {(N-2)'(0), message_bit};
          cnt_d        = CNT_W'(1);
          state_d      = S_MSG;
        end
      end

      S_MSG: begin
        if (load) begin
          lfsr_d       = lfsr_msg_step;
          code_bit_d   = message_bit;
          code_valid_d = 1'b1;
          sent_d       = {sent_q[N-3:0], message_bit};
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == MSG_LAST) begin
            state_d = S_PARITY;
          end
        end else begin
          // Short message: drop it without touching the published codeword.
          lfsr_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_PARITY: begin
        code_bit_d   = lfsr_q[P-1];
        code_valid_d = 1'b1;
        lfsr_d       = lfsr_par_step;
        sent_d       = {sent_q[N-3:0], lfsr_q[P-1]};
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == PAR_LAST) begin
          done_d     = 1'b1;
          codeword_d = {sent_q, lfsr_q[P-1]};
          lfsr_d     = '0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        lfsr_d  = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lfsr_q       <= '0;
      sent_q       <= '0;
      code_bit_q   <= 1'b0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      codeword_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      sent_q       <= sent_d;
      code_bit_q   <= code_bit_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      codeword_q   <= codeword_d;
    end
  end

  assign code_bit      = code_bit_q;
  assign code_valid    = code_valid_q;
  assign busy          = busy_q;
  assign codeword_done = done_q;
  assign codeword      = codeword_q;

endmodule
